// File: rtl/gat_bram_load_bridge.sv
// Write-side bridge from AXI-BRAM-controller ports to the GAT narrow internal BRAMs, with per-channel
// word counting and hardware load-done. Define GAT_BRIDGE_ALIGN_CHECK_EN to drop misaligned writes.
module gat_bram_load_bridge #(
    parameter int NUM_CH      = 3,
    parameter int DIN_W       = 32,
    parameter int BYTE_ADDR_W = 20,
    parameter int DATA_W      = 20,
    parameter int WORD_ADDR_W = BYTE_ADDR_W - 2,
    parameter int CNT_W       = 18
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cfg_valid,
    input  logic [NUM_CH*CNT_W-1:0]         cfg_depth,
    input  logic [NUM_CH*DIN_W-1:0]         s_din,
    input  logic [NUM_CH-1:0]               s_en,
    input  logic [NUM_CH-1:0]               s_we,
    input  logic [NUM_CH*BYTE_ADDR_W-1:0]   s_addr,
    output logic [NUM_CH*DATA_W-1:0]        m_din,
    output logic [NUM_CH-1:0]               m_we,
    output logic [NUM_CH*WORD_ADDR_W-1:0]   m_addr,
    output logic [NUM_CH-1:0]               load_done,
    output logic                            all_done,
    output logic [NUM_CH-1:0]               err_oob,
    output logic                            err_unexp,
    output logic [NUM_CH-1:0]               err_align
);

    // state  | meaning
    // S_IDLE | no load configured since reset
    // S_LOAD | accepting writes until every channel has reached its depth
    // S_DONE | all channels loaded; further writes are unexpected
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int CMP_W = (CNT_W > WORD_ADDR_W) ? CNT_W : WORD_ADDR_W;

    state_t r_state;
    state_t w_state_nxt;

    logic [CNT_W-1:0]               r_depth [NUM_CH];
    logic [CNT_W-1:0]               r_count [NUM_CH];
    logic [NUM_CH-1:0]              r_done;
    logic [NUM_CH-1:0]              r_m_we;
    logic [NUM_CH*DATA_W-1:0]       r_m_din;
    logic [NUM_CH*WORD_ADDR_W-1:0]  r_m_addr;
    logic [NUM_CH-1:0]              r_err_oob;
    logic [NUM_CH-1:0]              r_err_align;
    logic                           r_err_unexp;

    logic [WORD_ADDR_W-1:0]         w_waddr [NUM_CH];
    logic [NUM_CH-1:0]              w_wr;
    logic [NUM_CH-1:0]              w_oob;
    logic [NUM_CH-1:0]              w_misalign;
    logic [NUM_CH-1:0]              w_accept;
    logic                           w_unused_in;

    // Upper data bits and (without the alignment check) the byte-lane bits are intentionally dropped.
    assign w_unused_in = ^{s_din, s_addr};

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_wr[c]    = s_en[c] & s_we[c];
            w_waddr[c] = s_addr[c*BYTE_ADDR_W+2 +: WORD_ADDR_W];
            w_oob[c]   = r_done[c] | (CMP_W'(w_waddr[c]) >= CMP_W'(r_depth[c]));
`ifdef GAT_BRIDGE_ALIGN_CHECK_EN
            w_misalign[c] = (s_addr[c*BYTE_ADDR_W +: 2] != 2'b00);
`else
            w_misalign[c] = 1'b0;
`endif
            w_accept[c] = w_wr[c] & (r_state == S_LOAD) & ~cfg_valid
                        & ~w_oob[c] & ~w_misalign[c];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (cfg_valid) w_state_nxt = S_LOAD;
            S_LOAD: begin
                if (cfg_valid)     w_state_nxt = S_LOAD;
                else if (&r_done)  w_state_nxt = S_DONE;
            end
            S_DONE: if (cfg_valid) w_state_nxt = S_LOAD;
            default:               w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_done      <= '0;
            r_m_we      <= '0;
            r_m_din     <= '0;
            r_m_addr    <= '0;
            r_err_oob   <= '0;
            r_err_align <= '0;
            r_err_unexp <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_depth[c] <= '0;
                r_count[c] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_m_we  <= w_accept;
            if (cfg_valid) begin
                // A zero depth is complete immediately, so done comes straight from the new depth.
                r_err_oob   <= '0;
                r_err_align <= '0;
                r_err_unexp <= 1'b0;
                for (int c = 0; c < NUM_CH; c++) begin
                    r_depth[c] <= cfg_depth[c*CNT_W +: CNT_W];
                    r_count[c] <= '0;
                    r_done[c]  <= (cfg_depth[c*CNT_W +: CNT_W] == '0);
                end
            end else begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (w_accept[c]) begin
                        r_count[c]                          <= r_count[c] + CNT_W'(1);
                        r_m_din[c*DATA_W +: DATA_W]         <= s_din[c*DIN_W +: DATA_W];
                        r_m_addr[c*WORD_ADDR_W +: WORD_ADDR_W] <= w_waddr[c];
                        if ((r_count[c] + CNT_W'(1)) == r_depth[c]) begin
                            r_done[c] <= 1'b1;
                        end
                    end
                    if (w_wr[c]) begin
                        if (r_state != S_LOAD)  r_err_unexp    <= 1'b1;
                        else if (w_misalign[c]) r_err_align[c] <= 1'b1;
                        else if (w_oob[c])      r_err_oob[c]   <= 1'b1;
                    end
                end
            end
        end
    end

    assign m_din     = r_m_din;
    assign m_we      = r_m_we;
    assign m_addr    = r_m_addr;
    assign load_done = r_done;
    assign all_done  = (r_state == S_DONE);
    assign err_oob   = r_err_oob;
    assign err_unexp = r_err_unexp;
`ifdef GAT_BRIDGE_ALIGN_CHECK_EN
    assign err_align = r_err_align;
`else
    assign err_align = '0;
`endif

endmodule

// File: tb/tb_gat_bram_load_bridge.sv
// Directed and randomized bench for gat_bram_load_bridge against a cycle-level behavioural model.
module tb_gat_bram_load_bridge;

    localparam int NC = 3;
    localparam int DW = 20;
    localparam int AW = 18;
    localparam int BW = 20;
    localparam int CW = 18;
`ifdef GAT_BRIDGE_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_valid;
    logic [NC*CW-1:0]  cfg_depth;
    logic [NC*32-1:0]  s_din;
    logic [NC-1:0]     s_en;
    logic [NC-1:0]     s_we;
    logic [NC*BW-1:0]  s_addr;
    logic [NC*DW-1:0]  m_din;
    logic [NC-1:0]     m_we;
    logic [NC*AW-1:0]  m_addr;
    logic [NC-1:0]     load_done;
    logic              all_done;
    logic [NC-1:0]     err_oob;
    logic              err_unexp;
    logic [NC-1:0]     err_align;

    gat_bram_load_bridge dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_depth(cfg_depth),
        .s_din(s_din), .s_en(s_en), .s_we(s_we), .s_addr(s_addr),
        .m_din(m_din), .m_we(m_we), .m_addr(m_addr), .load_done(load_done),
        .all_done(all_done), .err_oob(err_oob), .err_unexp(err_unexp), .err_align(err_align)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // stimulus for the next cycle
    bit          in_rst, in_cfg;
    bit          in_en [NC];
    bit          in_we [NC];
    int unsigned in_addr [NC];
    int unsigned in_din [NC];
    int unsigned in_depth [NC];

    // reference model: phase 0 idle, 1 loading, 2 all loaded
    int          md_phase;
    int unsigned md_depth [NC];
    int unsigned md_count [NC];
    bit          md_done [NC];
    bit          md_oob [NC];
    bit          md_align [NC];
    bit          md_we [NC];
    bit          md_unexp;
    int unsigned md_din [NC];
    int unsigned md_addr [NC];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit loading, was_all;
        for (int c = 0; c < NC; c++) md_we[c] = 1'b0;
        if (in_rst) begin
            md_phase = 0;
            md_unexp = 1'b0;
            for (int c = 0; c < NC; c++) begin
                md_depth[c] = 0; md_count[c] = 0; md_done[c] = 0;
                md_oob[c] = 0; md_align[c] = 0; md_din[c] = 0; md_addr[c] = 0;
            end
        end else if (in_cfg) begin
            md_phase = 1;
            md_unexp = 1'b0;
            for (int c = 0; c < NC; c++) begin
                md_depth[c] = in_depth[c]; md_count[c] = 0;
                md_done[c] = (in_depth[c] == 0);
                md_oob[c] = 0; md_align[c] = 0;
            end
        end else begin
            loading = (md_phase == 1);
            was_all = 1'b1;
            for (int c = 0; c < NC; c++) if (!md_done[c]) was_all = 1'b0;
            for (int c = 0; c < NC; c++) begin
                if (in_en[c] && in_we[c]) begin
                    int unsigned word = in_addr[c] / 4;
                    if (!loading) md_unexp = 1'b1;
                    else if (ALIGN && (in_addr[c] % 4) != 0) md_align[c] = 1'b1;
                    else if (md_done[c] || word >= md_depth[c]) md_oob[c] = 1'b1;
                    else begin
                        md_we[c]   = 1'b1;
                        md_din[c]  = in_din[c] % (1 << DW);
                        md_addr[c] = word;
                        md_count[c]++;
                        if (md_count[c] == md_depth[c]) md_done[c] = 1'b1;
                    end
                end
            end
            if (loading && was_all) md_phase = 2;
        end
    endtask

    task automatic check_all();
        logic [NC*DW-1:0] e_din;
        logic [NC*AW-1:0] e_addr;
        logic [NC-1:0]    e_we, e_done, e_oob, e_align;
        for (int c = 0; c < NC; c++) begin
            e_din[c*DW +: DW]  = DW'(md_din[c]);
            e_addr[c*AW +: AW] = AW'(md_addr[c]);
            e_we[c]    = md_we[c];
            e_done[c]  = md_done[c];
            e_oob[c]   = md_oob[c];
            e_align[c] = md_align[c];
        end
        chk("m_we",      64'(m_we),      64'(e_we));
        chk("m_din",     64'(m_din),     64'(e_din));
        chk("m_addr",    64'(m_addr),    64'(e_addr));
        chk("load_done", 64'(load_done), 64'(e_done));
        chk("all_done",  64'(all_done),  64'(md_phase == 2));
        chk("err_oob",   64'(err_oob),   64'(e_oob));
        chk("err_unexp", 64'(err_unexp), 64'(md_unexp));
        chk("err_align", 64'(err_align), 64'(e_align));
    endtask

    task automatic cyc();
        rst       = in_rst;
        cfg_valid = in_cfg;
        for (int c = 0; c < NC; c++) begin
            s_en[c]               = in_en[c];
            s_we[c]               = in_we[c];
            s_addr[c*BW +: BW]    = BW'(in_addr[c]);
            s_din[c*32 +: 32]     = in_din[c];
            cfg_depth[c*CW +: CW] = CW'(in_depth[c]);
        end
        model_step();
        @(posedge clk);
        #1;
        check_all();
        in_rst = 0; in_cfg = 0;
        for (int c = 0; c < NC; c++) begin
            in_en[c] = 0; in_we[c] = 0;
        end
    endtask

    task automatic wr(input int c, input int unsigned byte_addr, input int unsigned data);
        in_en[c] = 1; in_we[c] = 1; in_addr[c] = byte_addr; in_din[c] = data;
    endtask

    task automatic cfg(input int unsigned d0, input int unsigned d1, input int unsigned d2);
        in_cfg = 1; in_depth[0] = d0; in_depth[1] = d1; in_depth[2] = d2;
    endtask

    initial begin
        for (int c = 0; c < NC; c++) begin
            in_en[c] = 0; in_we[c] = 0; in_addr[c] = 0; in_din[c] = 0; in_depth[c] = 0;
        end
        in_cfg = 0;

        // reset state
        in_rst = 1; cyc();
        in_rst = 1; cyc();
        cyc();

        // write while idle, then a read
        wr(0, 4, 32'h1234_5678); cyc();
        in_en[1] = 1; cyc();
        cyc();

        // basic load {4,2,3}
        cfg(4, 2, 3); cyc();
        for (int i = 0; i < 4; i++) begin
            wr(0, 4 * i, 32'hABCDE123);
            if (i < 2) wr(1, 4 * i, 32'hABCDE123);
            if (i < 3) wr(2, 4 * i, 32'hABCDE123);
            cyc();
        end
        repeat (3) cyc();

        // write while done
        wr(2, 0, 32'hFFFF_0001); cyc();
        cyc();

        // out of range and write after done
        cfg(2, 3, 3); cyc();
        wr(0, 8, 32'h0000_0AAA); cyc();
        wr(0, 0, 32'h0000_0BBB); cyc();
        wr(0, 4, 32'h0000_0CCC); cyc();
        wr(0, 0, 32'h0000_0DDD); cyc();
        cyc();

        // restart collision, then all-zero depth
        cfg(3, 3, 3); cyc();
        wr(0, 0, 32'h0005_5555); cyc();
        cfg(1, 1, 1); wr(0, 4, 32'h0006_6666); cyc();
        wr(0, 0, 32'h0007_7777); wr(1, 0, 32'h0008_8888); wr(2, 0, 32'h0009_9999); cyc();
        repeat (2) cyc();
        cfg(0, 0, 0); cyc();
        repeat (3) cyc();

        // alignment behaviour
        cfg(4, 1, 1); cyc();
        wr(0, 6, 32'h000C_AFE1); cyc();
        wr(0, 5, 32'h000C_AFE2); wr(1, 0, 32'h0001_1111); cyc();
        repeat (2) cyc();

        // randomized rounds
        for (int r = 0; r < 8; r++) begin
            cfg($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6)); cyc();
            for (int k = 0; k < 40; k++) begin
                if ($urandom_range(0, 29) == 0) begin
                    cfg($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
                end
                for (int c = 0; c < NC; c++) begin
                    in_en[c]   = ($urandom_range(0, 1) == 1);
                    in_we[c]   = ($urandom_range(0, 3) != 0);
                    in_addr[c] = 4 * $urandom_range(0, 7) +
                                 (($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
                    in_din[c]  = $urandom;
                end
                cyc();
            end
        end

        // reset during a write burst, then a fresh load
        cfg(3, 3, 3); cyc();
        wr(0, 0, 32'h1111); wr(1, 0, 32'h2222); wr(2, 0, 32'h3333); cyc();
        wr(0, 4, 32'h4444); wr(1, 4, 32'h5555); wr(2, 4, 32'h6666); in_rst = 1; cyc();
        cyc();
        cfg(1, 1, 1); cyc();
        wr(0, 0, 32'h7777); wr(1, 0, 32'h8888); wr(2, 0, 32'h9999); cyc();
        repeat (2) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
